// File: rtl/ram_load_merge_pkg.sv
// Shared definitions for the load-merge slice: load-type and FSM encodings,
// beat geometry and small decode helpers.
package ram_load_merge_pkg;

    typedef enum logic [2:0] {
        LT_ILLEGAL = 3'b000,
        LT_LB      = 3'b001,
        LT_LH      = 3'b010,
        LT_LW      = 3'b011,
        LT_LD      = 3'b100,
        LT_LBU     = 3'b101,
        LT_LHU     = 3'b110,
        LT_LWU     = 3'b111
    } load_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Bytes per memory beat.
    function automatic int beat_bytes(input int data_w);
        return data_w / 8;
    endfunction

    // Access size in bytes; 0 for the illegal encoding.
    function automatic logic [3:0] load_size(input logic [2:0] load_type);
        case (load_type_e'(load_type))
            LT_LB, LT_LBU: return 4'd1;
            LT_LH, LT_LHU: return 4'd2;
            LT_LW, LT_LWU: return 4'd4;
            LT_LD:         return 4'd8;
            default:       return 4'd0;
        endcase
    endfunction

    // Signed loads sign-extend from the top bit of their size.
    function automatic logic load_signed(input logic [2:0] load_type);
        case (load_type_e'(load_type))
            LT_LB, LT_LH, LT_LW, LT_LD: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_load_merge_if.sv
// Request/response and memory-side bus of the load-merge unit.
// slave is the unit's own view, master is the surrounding environment.
interface ram_load_merge_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_load_type;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    modport slave (
        input  req_valid, req_addr, req_load_type, resp_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, resp_valid, resp_data, resp_err,
               mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, req_load_type, resp_ready,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, resp_valid, resp_data, resp_err,
               mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ram_load_merge_load_extend.sv
// Combinational extract/mask/extend: shifts the two-beat window down to the
// load offset, keeps 'size' bytes and sign- or zero-extends to DATA_W.
module load_extend
    import ram_load_merge_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]              beat0,
    input  logic [DATA_W-1:0]              beat1,
    input  logic [$clog2(DATA_W/8)-1:0]    offset,
    input  logic [2:0]                     load_type,
    output logic [DATA_W-1:0]              result
);
    logic [2*DATA_W-1:0]      merged;
    logic [DATA_W-1:0]        window;
    logic [DATA_W-1:0]        left_u;
    logic signed [DATA_W-1:0] left_s;
    logic [7:0]               pad;

    // Push the wanted bytes to the top, then shift back arithmetically or logically.
    always_comb begin
        merged = {beat1, beat0} >> {offset, 3'b000};
        window = merged[DATA_W-1:0];
        pad    = 8'(DATA_W) - {1'b0, load_size(load_type), 3'b000};
        left_u = window << pad;
        left_s = signed'(left_u);
        result = load_signed(load_type) ? unsigned'(left_s >>> pad) : (left_u >> pad);
    end
endmodule

// File: rtl/ram_load_merge.sv
// Load unit that fetches one or two aligned memory beats for a byte-addressed
// load and merges them into an extended result. One load outstanding at a time.
module ram_load_merge
    import ram_load_merge_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int MISALIGN_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    ram_load_merge_if.slave bus
);
    localparam int BYTES = beat_bytes(DATA_W);
    localparam int OFF_W = $clog2(BYTES);

    state_e            state;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        type_q;
    logic [DATA_W-1:0] beat0_q;
    logic [DATA_W-1:0] beat1_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_req_addr_q;

    logic [3:0]        in_size;
    logic [OFF_W-1:0]  in_off;
    logic              in_illegal;
    logic              in_misaligned;
    logic [4:0]        span;
    logic              crosses;
    logic [DATA_W-1:0] ext_beat0;
    logic [DATA_W-1:0] ext_beat1;
    logic [DATA_W-1:0] ext_result;

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;

    // Classify the incoming request and decide whether the held one spans two beats.
    always_comb begin
        in_size       = load_size(bus.req_load_type);
        in_off        = bus.req_addr[OFF_W-1:0];
        in_illegal    = (bus.req_load_type == LT_ILLEGAL) ||
                        ((DATA_W == 32) && (bus.req_load_type == LT_LD));
        in_misaligned = (in_off & OFF_W'(in_size - 4'd1)) != '0;
        span          = 5'(off_q) + 5'(load_size(type_q));
        crosses       = span > 5'(BYTES);
        // Bypass the arriving beat so the result can be registered on capture.
        ext_beat0     = (state == ST_WAIT0) ? bus.mem_rsp_data : beat0_q;
        ext_beat1     = (state == ST_WAIT1) ? bus.mem_rsp_data : beat1_q;
    end

    load_extend #(.DATA_W(DATA_W)) u_extend (
        .beat0     (ext_beat0),
        .beat1     (ext_beat1),
        .offset    (off_q),
        .load_type (type_q),
        .result    (ext_result)
    );

    // Control FSM with registered handshake, memory and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            off_q           <= '0;
            type_q          <= '0;
            beat0_q         <= '0;
            beat1_q         <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        off_q       <= in_off;
                        type_q      <= bus.req_load_type;
                        req_ready_q <= 1'b0;
                        if (in_illegal || (in_misaligned && (MISALIGN_EN == 0))) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else begin
                            state           <= ST_REQ0;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                ST_REQ0: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (bus.mem_rsp_valid) begin
                        beat0_q <= bus.mem_rsp_data;
                        if (crosses) begin
                            state           <= ST_REQ1;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= mem_req_addr_q + ADDR_W'(BYTES);
                        end else begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_data_q  <= ext_result;
                        end
                    end
                end
                ST_REQ1: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (bus.mem_rsp_valid) begin
                        beat1_q      <= bus.mem_rsp_data;
                        state        <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= ext_result;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= '0;
                        req_ready_q  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_load_merge.sv
// Scoreboard bench for ram_load_merge: directed loads push expected responses
// and memory accesses into queues; monitors pop and compare as the DUT emits them.
module tb_ram_load_merge;
    import ram_load_merge_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    ram_load_merge_if #(.DATA_W(64), .ADDR_W(64)) bus ();
    ram_load_merge_if #(.DATA_W(64), .ADDR_W(64)) bus0 ();

    ram_load_merge #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ram_load_merge #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic        drop;
    } mem_t;

    exp_t q[$];
    exp_t q0[$];
    mem_t mq[$];

    int compared   = 0;
    int mismatched = 0;

    int stall_budget = 0, stall_taken = 0;
    int hold_budget  = 0, hold_taken  = 0;
    int inject_at    = -1;
    logic drop_seen  = 1'b0;
    int mem0_hits    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Memory model for dut: zero-wait unless stalled, answers one cycle after the handshake.
    logic        pend = 1'b0;
    logic [63:0] pend_data;
    always @(negedge clk) begin
        mem_t m;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        if (rst) begin
            pend = 1'b0;
            bus.mem_req_ready = 1'b1;
        end else begin
            if (pend) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = pend_data;
                pend = 1'b0;
            end else if (cyc == inject_at) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            if (bus.mem_req_valid && (stall_taken < stall_budget)) begin
                bus.mem_req_ready = 1'b0;
                stall_taken++;
            end else begin
                bus.mem_req_ready = 1'b1;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (mq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_mem_access: got addr 0x%h, expected none", bus.mem_req_addr);
                end else begin
                    m = mq.pop_front();
                    check("mem_addr", bus.mem_req_addr, m.addr);
                    if (m.drop) drop_seen = 1'b1;
                    else begin
                        pend      = 1'b1;
                        pend_data = m.data;
                    end
                end
            end
        end
    end

    // Response monitor for dut: stability/busy checks while valid, compare on handshake.
    logic        seen = 1'b0;
    int          first_cyc;
    logic [63:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
            bus.resp_ready = 1'b1;
        end else if (bus.resp_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
                held      = bus.resp_data;
            end else begin
                check("resp_data_stable", bus.resp_data, held);
            end
            check("req_ready_busy", 64'(bus.req_ready), 64'd0);
            if (hold_taken < hold_budget) begin
                bus.resp_ready = 1'b0;
                hold_taken++;
            end else begin
                bus.resp_ready = 1'b1;
                seen = 1'b0;
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_resp: got data 0x%h, expected no response", bus.resp_data);
                end else begin
                    e = q.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_err", 64'(bus.resp_err), 64'(e.err));
                    if (e.lat > 0) check("resp_latency", 64'(first_cyc - e.acc), 64'(e.lat));
                end
            end
        end else begin
            bus.resp_ready = 1'b1;
        end
    end

    // Response monitor for dut0 (misaligned loads rejected): always ready.
    always @(negedge clk) begin
        exp_t e;
        bus0.resp_ready = 1'b1;
        if (!rst) begin
            if (bus0.mem_req_valid) mem0_hits++;
            if (bus0.resp_valid) begin
                if (q0.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_resp0: got data 0x%h, expected no response", bus0.resp_data);
                end else begin
                    e = q0.pop_front();
                    check("resp0_data", bus0.resp_data, e.data);
                    check("resp0_err", 64'(bus0.resp_err), 64'(e.err));
                    check("resp0_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
        end
    end

    task automatic mem(input logic [63:0] addr, input logic [63:0] data, input logic drop);
        mq.push_back('{addr, data, drop});
    endtask

    task automatic issue(input logic [63:0] addr, input logic [2:0] t, input logic [63:0] d,
                         input logic e, input int lat, input logic expect_resp);
        int n = 0;
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_addr      = addr;
        bus.req_load_type = t;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL req_accept_timeout: got req_ready 0, expected 1");
        end else if (expect_resp) begin
            q.push_back('{d, e, cyc, lat});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic issue0(input logic [63:0] addr, input logic [2:0] t);
        int n = 0;
        @(negedge clk);
        bus0.req_valid     = 1'b1;
        bus0.req_addr      = addr;
        bus0.req_load_type = t;
        while (!bus0.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus0.req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL req0_accept_timeout: got req_ready 0, expected 1");
        end else begin
            q0.push_back('{64'd0, 1'b1, cyc, 1});
        end
        @(negedge clk);
        bus0.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || q0.size() != 0 || mq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending, expected 0", q.size(), q0.size(), mq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_data", bus.resp_data, 64'd0);
        check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_mem_req_addr", bus.mem_req_addr, 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_addr        = '0;
        bus.req_load_type   = '0;
        bus0.req_valid      = 1'b0;
        bus0.req_addr       = '0;
        bus0.req_load_type  = '0;
        bus0.mem_req_ready  = 1'b1;
        bus0.mem_rsp_valid  = 1'b0;
        bus0.mem_rsp_data   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Single-beat loads
        mem(64'h1000, 64'h0000_0000_8000_0000, 1'b0);
        issue(64'h1003, LT_LB,  64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1'b1);
        mem(64'h2000, 64'h8765_4321_0000_0000, 1'b0);
        issue(64'h2004, LT_LWU, 64'h0000_0000_8765_4321, 1'b0, 3, 1'b1);
        mem(64'h5000, 64'h0123_4567_89AB_CDEF, 1'b0);
        issue(64'h5000, LT_LD,  64'h0123_4567_89AB_CDEF, 1'b0, 3, 1'b1);
        mem(64'h6000, 64'h0000_9A00_0000_0000, 1'b0);
        issue(64'h6005, LT_LBU, 64'h0000_0000_0000_009A, 1'b0, 3, 1'b1);
        mem(64'h7000, 64'h8000_0001_0000_0000, 1'b0);
        issue(64'h7004, LT_LW,  64'hFFFF_FFFF_8000_0001, 1'b0, 3, 1'b1);
        mem(64'h8000, 64'hF00D_0000_0000_0000, 1'b0);
        issue(64'h8006, LT_LHU, 64'h0000_0000_0000_F00D, 1'b0, 3, 1'b1);
        mem(64'hC000, 64'h0000_0000_0000_8000, 1'b0);
        issue(64'hC001, LT_LH,  64'h0000_0000_0000_0080, 1'b0, 3, 1'b1);

        // Split loads
        mem(64'h3000, 64'hAB00_0000_0000_0000, 1'b0);
        mem(64'h3008, 64'h0000_0000_0000_00CD, 1'b0);
        issue(64'h3007, LT_LH,  64'hFFFF_FFFF_FFFF_CDAB, 1'b0, 5, 1'b1);
        mem(64'h9008, 64'h1111_2222_3333_4444, 1'b0);
        mem(64'h9010, 64'h5555_6666_7777_8888, 1'b0);
        issue(64'h900C, LT_LD,  64'h7777_8888_1111_2222, 1'b0, 5, 1'b1);
        mem(64'h0A00, 64'hBEEF_0000_0000_0000, 1'b0);
        mem(64'h0A08, 64'h0000_0000_0000_DEAD, 1'b0);
        issue(64'h0A06, LT_LW,  64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 5, 1'b1);
        mem(64'hFFFF_FFFF_FFFF_FFF8, 64'h7F00_0000_0000_0000, 1'b0);
        mem(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0012, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, LT_LH, 64'h0000_0000_0000_127F, 1'b0, 5, 1'b1);

        // Illegal type: error response, no memory access
        issue(64'hB000, LT_ILLEGAL, 64'd0, 1'b1, 1, 1'b1);

        // Rejected misaligned / illegal loads on the non-splitting instance
        issue0(64'h4004, LT_LD);
        issue0(64'h4001, LT_LH);
        issue0(64'hB000, LT_ILLEGAL);
        wait_idle();

        // Memory stall in REQ0 plus a slow consumer
        stall_budget = stall_taken + 3;
        hold_budget  = hold_taken + 4;
        mem(64'hD000, 64'h0000_0000_0000_00FF, 1'b0);
        issue(64'hD000, LT_LB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6, 1'b1);
        wait_idle();

        // Reset while waiting for the second beat, then a stray memory response
        mem(64'h3000, 64'hAB00_0000_0000_0000, 1'b0);
        mem(64'h3008, 64'h0000_0000_0000_00CD, 1'b1);
        issue(64'h3007, LT_LH, 64'd0, 1'b0, 0, 1'b0);
        n = 0;
        while (!drop_seen && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!drop_seen) begin
            compared++;
            mismatched++;
            $display("FAIL second_beat_timeout: got no REQ1 handshake, expected one");
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        inject_at = cyc + 1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            check("post_rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        end
        check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        mem(64'hE000, 64'h0000_0000_0000_7F00, 1'b0);
        issue(64'hE001, LT_LB, 64'h0000_0000_0000_007F, 1'b0, 3, 1'b1);
        wait_idle();

        check("dut0_mem_accesses", 64'(mem0_hits), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
